pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, PC and immediate width in bits (min 8).
REQ-002 SHALL provide parameter RAS_DEPTH, default 8, return-address stack entries (power of two, min 2).
REQ-003 SHALL provide parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 SHALL provide port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port stall  input  1  holds all state when high.
REQ-007 SHALL provide port sig_pc_src  input  2  next-PC select: 00 pc_next, 01 pc_topofstack, 10 pc_BTA, 11 pc_JA.
REQ-008 SHALL provide port sig_call  input  1  with pc_JA, push the return address.
REQ-009 SHALL provide port I_TypeImmediate  input  WIDTH  sign-extended branch offset.
REQ-010 SHALL provide port J_TypeImmediate  input  WIDTH-6  jump target field.
REQ-011 SHALL provide port PC  output  WIDTH  registered program counter.
REQ-012 SHALL provide port ras_count  output  clog2(RAS_DEPTH)+1  valid stack entries.
REQ-013 SHALL provide ports ras_empty, ras_full  output  1 each  combinational from ras_count.
REQ-014 SHALL provide ports ras_overflow, ras_underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL compute all next-PC candidates from the current registered PC; PC updates one rising edge after select is sampled; no combinational path from inputs to PC.
REQ-016 pc_next SHALL load PC+1, modulo 2^WIDTH (all-ones wraps to 0).
REQ-017 pc_BTA SHALL load PC+I_TypeImmediate, two's-complement, modulo 2^WIDTH.
REQ-018 pc_JA SHALL load {PC[WIDTH-1:WIDTH-6], J_TypeImmediate}.
REQ-019 pc_JA with sig_call=1 SHALL push PC+1 and increment ras_count in the same edge.
REQ-020 sig_call SHALL be ignored unless sig_pc_src=pc_JA.
REQ-021 pc_topofstack with ras_count>0 SHALL load the most recent pushed entry and decrement ras_count.
REQ-022 Push when full SHALL overwrite the oldest entry (circular), keep ras_count=RAS_DEPTH, set ras_overflow.
REQ-023 pc_topofstack when empty SHALL load PC+1, leave ras_count 0, set ras_underflow.
REQ-024 ras_overflow and ras_underflow SHALL remain set until reset.
REQ-025 stall=1 SHALL hold PC, stack contents, ras_count and flags regardless of other inputs.
REQ-026 Stack storage SHALL be a circular buffer with WIDTH-bit entries and a top pointer; pointer wraps modulo RAS_DEPTH.

Reset
REQ-027 reset=1 at a rising edge SHALL set PC=RESET_VECTOR, ras_count=0, ras_overflow=0, ras_underflow=0; stack contents need not clear.
REQ-028 reset SHALL take priority over stall and any select, including mid push/pop.
REQ-029 First post-reset update SHALL occur at the first edge with reset=0.

Verification
REQ-030 Sequential: reset, then 4 cycles pc_next -> PC 0,1,2,3,4; PC=32'hFFFFFFFF plus pc_next -> PC=0.
REQ-031 Branch: PC=0x10, pc_BTA, I_TypeImmediate=0xFFFFFFFC -> PC=0x0C; then I=0x20 -> PC=0x2C.
REQ-032 Call/return: PC=0x40, pc_JA+sig_call, J=0x100 -> PC=0x100, ras_count=1; pc_topofstack -> PC=0x41, ras_count=0, ras_empty=1.
REQ-033 Overflow: RAS_DEPTH=8, 9 nested calls from PCs 0x10..0x18 -> ras_full=1, ras_overflow=1; 8 returns -> 0x19,0x18,...,0x12; ninth return -> ras_underflow=1, PC=previous PC+1.
REQ-034 Stall/reset: stall=1 with pc_JA+sig_call -> PC, ras_count unchanged; reset asserted with stall=1 -> PC=RESET_VECTOR, flags and ras_count cleared next edge.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC selection and a circular return-address stack.
// Every candidate target is derived from the registered PC, so no input reaches PC combinationally.
module pc_stack_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      RAS_DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   sig_pc_src,
  input  logic                         sig_call,
  input  logic [WIDTH-1:0]             I_TypeImmediate,
  input  logic [WIDTH-7:0]             J_TypeImmediate,
  output logic [WIDTH-1:0]             PC,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    SrcNext = 2'b00,
    SrcTos  = 2'b01,
    SrcBta  = 2'b10,
    SrcJa   = 2'b11
  } pc_src_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PtrW-1:0]  top_q, top_d, top_inc;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc, pc_bta, pc_ja;
  logic             cnt_zero, cnt_max;

  assign pc_inc   = pc_q + WIDTH'(1);
  assign pc_bta   = pc_q + I_TypeImmediate;
  assign pc_ja    = {pc_q[WIDTH-1:WIDTH-6], J_TypeImmediate};
  assign top_inc  = top_q + PtrW'(1);
  assign cnt_zero = (cnt_q == '0);
  assign cnt_max  = (cnt_q == CntW'(RAS_DEPTH));

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    unique case (pc_src_e'(sig_pc_src))
      SrcNext: pc_d = pc_inc;
      SrcBta:  pc_d = pc_bta;
      SrcJa: begin
        pc_d = pc_ja;
        if (sig_call) begin
          // When full, the slot after top holds the oldest entry and is overwritten.
          push  = 1'b1;
          top_d = top_inc;
          if (cnt_max) ovf_d = 1'b1;
          else         cnt_d = cnt_q + CntW'(1);
        end
      end
      SrcTos: begin
        if (cnt_zero) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d  = stack_q[top_q];
          top_d = top_q - PtrW'(1);
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!stall) begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage needs no reset; only the pointer and count define validity.
  always_ff @(posedge clock) begin
    if (!reset && !stall && push) begin
      stack_q[top_inc] <= pc_inc;
    end
  end

  assign PC            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_empty     = cnt_zero;
  assign ras_full      = cnt_max;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a vector table for the basic flows plus hand-written
// overflow/underflow and stall/reset sequences.
module tb_pc_stack_unit;

  localparam logic [1:0] NXT = 2'b00, TOS = 2'b01, BTA = 2'b10, JA = 2'b11;
  // flag order {empty, full, overflow, underflow}
  localparam logic [3:0] FE = 4'b1000, F0 = 4'b0000;

  logic        clk = 1'b0;
  logic        reset, stall, sig_call;
  logic [1:0]  sig_pc_src;
  logic [31:0] I_TypeImmediate;
  logic [25:0] J_TypeImmediate;
  logic [31:0] PC;
  logic [3:0]  ras_count;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(
    .WIDTH       (32),
    .RAS_DEPTH   (8),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .stall          (stall),
    .sig_pc_src     (sig_pc_src),
    .sig_call       (sig_call),
    .I_TypeImmediate(I_TypeImmediate),
    .J_TypeImmediate(J_TypeImmediate),
    .PC             (PC),
    .ras_count      (ras_count),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  src;
    logic        call;
    logic [31:0] imm;
    logic [25:0] j;
    logic [31:0] epc;
    logic [3:0]  ecnt;
    logic [3:0]  efl;
  } vec_t;

  vec_t vecs[$];

  task automatic apply(input logic r, input logic s, input logic [1:0] src, input logic c,
                       input logic [31:0] imm, input logic [25:0] j);
    @(negedge clk);
    reset           = r;
    stall           = s;
    sig_pc_src      = src;
    sig_call        = c;
    I_TypeImmediate = imm;
    J_TypeImmediate = j;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] epc, input logic [3:0] ecnt,
                       input logic [3:0] efl);
    logic [3:0] fl;
    fl = {ras_empty, ras_full, ras_overflow, ras_underflow};
    total++;
    if (PC === epc && ras_count === ecnt && fl === efl) begin
      passed++;
    end else begin
      $display("FAIL %s: got pc=%h cnt=%0d flags(e,f,o,u)=%b, expected pc=%h cnt=%0d flags=%b",
               nm, PC, ras_count, fl, epc, ecnt, efl);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; sig_pc_src = NXT; sig_call = 1'b0;
    I_TypeImmediate = '0; J_TypeImmediate = '0;

    //           rst   stl  src  call imm            j           epc           cnt   flags
    vecs.push_back('{1'b1, 1'b0, JA,  1'b1, 32'h0,        26'h123,   32'h0,        4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, NXT, 1'b0, 32'h0,        26'h0,     32'h1,        4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, NXT, 1'b0, 32'h0,        26'h0,     32'h2,        4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, NXT, 1'b0, 32'h0,        26'h0,     32'h3,        4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, NXT, 1'b0, 32'h0,        26'h0,     32'h4,        4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, BTA, 1'b0, 32'hFFFFFFFB, 26'h0,     32'hFFFFFFFF, 4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, NXT, 1'b0, 32'h0,        26'h0,     32'h0,        4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, JA,  1'b0, 32'h0,        26'h10,    32'h10,       4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, BTA, 1'b0, 32'hFFFFFFFC, 26'h0,     32'h0C,       4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, BTA, 1'b0, 32'h20,       26'h0,     32'h2C,       4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, JA,  1'b0, 32'h0,        26'h40,    32'h40,       4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, JA,  1'b1, 32'h0,        26'h100,   32'h100,      4'd1, F0});
    vecs.push_back('{1'b0, 1'b0, TOS, 1'b0, 32'h0,        26'h0,     32'h41,       4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, NXT, 1'b1, 32'h0,        26'h0,     32'h42,       4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, BTA, 1'b1, 32'h2,        26'h0,     32'h44,       4'd0, FE});
    vecs.push_back('{1'b0, 1'b0, JA,  1'b1, 32'h0,        26'h200,   32'h200,      4'd1, F0});
    vecs.push_back('{1'b0, 1'b1, JA,  1'b1, 32'h0,        26'h300,   32'h200,      4'd1, F0});
    vecs.push_back('{1'b0, 1'b1, TOS, 1'b0, 32'h0,        26'h0,     32'h200,      4'd1, F0});
    vecs.push_back('{1'b0, 1'b0, TOS, 1'b0, 32'h0,        26'h0,     32'h45,       4'd0, FE});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].stl, vecs[i].src, vecs[i].call, vecs[i].imm, vecs[i].j);
      check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ecnt, vecs[i].efl);
    end

    // Nine nested calls from 0x10..0x18 into an 8-deep stack.
    apply(1'b0, 1'b0, JA, 1'b0, 32'h0, 26'h10);
    check("ovf_start", 32'h10, 4'd0, FE);
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 1'b0, JA, 1'b1, 32'h0, 26'(32'h11 + i));
      check($sformatf("call%0d", i), 32'h11 + 32'(i), (i >= 7) ? 4'd8 : 4'(i + 1),
            {1'b0, i >= 7, i == 8, 1'b0});
    end
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, TOS, 1'b0, 32'h0, 26'h0);
      check($sformatf("ret%0d", k), 32'h19 - 32'(k), 4'(7 - k), {k == 7, 1'b0, 1'b1, 1'b0});
    end
    apply(1'b0, 1'b0, TOS, 1'b0, 32'h0, 26'h0);
    check("ret_underflow", 32'h13, 4'd0, 4'b1011);
    apply(1'b0, 1'b0, NXT, 1'b0, 32'h0, 26'h0);
    check("flags_sticky", 32'h14, 4'd0, 4'b1011);
    apply(1'b0, 1'b0, JA, 1'b1, 32'h0, 26'h50);
    check("push_after_wrap", 32'h50, 4'd1, 4'b0011);

    // Reset wins over stall and a pending call.
    apply(1'b1, 1'b1, JA, 1'b1, 32'h0, 26'h77);
    check("reset_over_stall", 32'h0, 4'd0, FE);
    apply(1'b0, 1'b0, NXT, 1'b0, 32'h0, 26'h0);
    check("first_post_reset", 32'h1, 4'd0, FE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
